// File: rtl/router_pkg.sv
// router_pkg -- shared definitions for the processor/network interface.
//
// Holds the flit header layout, the header packing and direction helpers,
// and the TX/RX state encodings used by proc_net_interface.
//
// Header layout, MSB first:
//   dst_x (XW) | dst_y (YW) | deltax | deltay | payload (N-XW-YW-2)
// Field positions depend on N/XW/YW, so they are exposed as constant
// functions that can be used in parameter and localparam expressions.
package router_pkg;

  // Widest flit the packing helper supports. Callers cast the result
  // down to their own flit width.
  localparam int PKT_MAX_W = 128;

  // deltax and deltay together.
  localparam int HDR_CTRL_BITS = 2;

  // Header field offsets (bit index of the field's LSB within the flit).
  function automatic int hdr_dst_x_lsb(input int n, input int xw);
    return n - xw;
  endfunction

  function automatic int hdr_dst_y_lsb(input int n, input int xw, input int yw);
    return n - xw - yw;
  endfunction

  function automatic int hdr_deltax_bit(input int n, input int xw, input int yw);
    return n - xw - yw - 1;
  endfunction

  function automatic int hdr_deltay_bit(input int n, input int xw, input int yw);
    return n - xw - yw - 2;
  endfunction

  function automatic int hdr_payload_w(input int n, input int xw, input int yw);
    return n - xw - yw - HDR_CTRL_BITS;
  endfunction

  // Direction bit: 1 when the destination lies above our own coordinate.
  function automatic logic delta(input logic [31:0] dst, input logic [31:0] src);
    return (dst > src);
  endfunction

  // Packs the header fields into a flit. Inputs must already be
  // zero-extended from their own field widths.
  function automatic logic [PKT_MAX_W-1:0] pack_header(
    input int                   n,
    input int                   xw,
    input int                   yw,
    input logic [PKT_MAX_W-1:0] dst_x,
    input logic [PKT_MAX_W-1:0] dst_y,
    input logic                 deltax,
    input logic                 deltay,
    input logic [PKT_MAX_W-1:0] payload
  );
    logic [PKT_MAX_W-1:0] flit;
    flit = payload;
    flit = flit | (PKT_MAX_W'(deltay) << hdr_deltay_bit(n, xw, yw));
    flit = flit | (PKT_MAX_W'(deltax) << hdr_deltax_bit(n, xw, yw));
    flit = flit | (dst_y << hdr_dst_y_lsb(n, xw, yw));
    flit = flit | (dst_x << hdr_dst_x_lsb(n, xw));
    return flit;
  endfunction

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_HOLD = 1'b1
  } rx_state_t;

endpackage

// File: rtl/phase_sync.sv
// phase_sync -- multi-flop synchronizer for a 1-bit 2-phase handshake line.
//
// Ports:
//   clk, rst  destination clock, synchronous active-high reset (clears all flops)
//   d         asynchronous phase input
//   q         phase after STAGES flops
module phase_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/proc_net_interface.sv
// proc_net_interface -- bridges a processor valid/ready port to a router's
// 2-phase bundled-data handshake, in both directions.
//
// Ports:
//   clk, rst                       single clock, synchronous active-high reset
//   tx_valid/tx_ready              processor packet offer / accept
//   tx_dst_x, tx_dst_y, tx_payload packet fields packed into the outgoing flit
//   tx_err                         one-cycle pulse: self-addressed packet dropped
//   rx_valid/rx_ready/rx_data      received flit towards the processor
//   net_out_req/data/ack           2-phase link to the router proc_input
//   net_in_req/data/ack            2-phase link from the router proc_output
//
// Handshakes: a processor-side transfer happens on every clock edge where
// valid and ready are both 1. A network-side transfer starts with a toggle
// of req (data already stable) and completes when ack equals req again.
//
// Build option: define PNI_RX_BUF_EN to put a 2-entry FIFO on the RX path,
// so the router is acknowledged without waiting for the processor.
module proc_net_interface
  import router_pkg::*;
#(
  parameter int N           = 32,
  parameter int XW          = 1,
  parameter int YW          = 1,
  parameter int SRCX        = 0,
  parameter int SRCY        = 0,
  parameter int SYNC_STAGES = 2,
  localparam int PW         = N - XW - YW - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic [XW-1:0] tx_dst_x,
  input  logic [YW-1:0] tx_dst_y,
  input  logic [PW-1:0] tx_payload,
  output logic          tx_err,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [N-1:0]  rx_data,
  output logic          net_out_req,
  output logic [N-1:0]  net_out_data,
  input  logic          net_out_ack,
  input  logic          net_in_req,
  input  logic [N-1:0]  net_in_data,
  output logic          net_in_ack
);

  logic ack_sync;
  logic req_sync;

  phase_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk), .rst (rst), .d (net_out_ack), .q (ack_sync)
  );

  phase_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk), .rst (rst), .d (net_in_req), .q (req_sync)
  );

  // ---------------- TX path ----------------
  tx_state_t    tx_state, tx_next;
  logic         tx_self, tx_load, tx_toggle, tx_drop;
  logic [N-1:0] tx_flit;

  always_comb begin
    tx_next   = tx_state;
    tx_load   = 1'b0;
    tx_toggle = 1'b0;
    tx_drop   = 1'b0;
    tx_self   = (tx_dst_x == XW'(SRCX)) && (tx_dst_y == YW'(SRCY));
    tx_flit   = N'(pack_header(N, XW, YW, PKT_MAX_W'(tx_dst_x), PKT_MAX_W'(tx_dst_y),
                               delta(32'(tx_dst_x), 32'(SRCX)),
                               delta(32'(tx_dst_y), 32'(SRCY)),
                               PKT_MAX_W'(tx_payload)));
    case (tx_state)
      TX_IDLE: begin
        // tx_ready is registered, so it also gates the first cycle after reset.
        if (tx_valid && tx_ready) begin
          if (tx_self) begin
            tx_drop = 1'b1;
          end else begin
            tx_load = 1'b1;
            tx_next = TX_SETUP;
          end
        end
      end
      TX_SETUP: begin
        // Data was latched last edge; toggling req now gives the router a
        // full cycle of settled bundled data.
        tx_toggle = 1'b1;
        tx_next   = TX_WAIT;
      end
      TX_WAIT: begin
        if (ack_sync == net_out_req) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state     <= TX_IDLE;
      tx_ready     <= 1'b0;
      tx_err       <= 1'b0;
      net_out_req  <= 1'b0;
      net_out_data <= '0;
    end else begin
      tx_state <= tx_next;
      tx_ready <= (tx_next == TX_IDLE);
      tx_err   <= tx_drop;
      if (tx_load)   net_out_data <= tx_flit;
      if (tx_toggle) net_out_req  <= ~net_out_req;
    end
  end

  // ---------------- RX path ----------------
  rx_state_t rx_state, rx_next;
  logic      rx_capture, rx_ack_toggle;

`ifdef PNI_RX_BUF_EN
  // RX_IDLE: waiting for a new phase with room in the FIFO.
  // RX_HOLD: flit pushed last edge; acknowledge it now.
  logic [N-1:0] fifo_mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   fifo_count;
  logic         fifo_full, rx_pop;

  assign fifo_full = (fifo_count == 2'd2);
  assign rx_valid  = (fifo_count != 2'd0);
  assign rx_data   = fifo_mem[rd_ptr];
  assign rx_pop    = rx_valid && rx_ready;

  always_comb begin
    rx_next       = rx_state;
    rx_capture    = 1'b0;
    rx_ack_toggle = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if ((req_sync != net_in_ack) && !fifo_full) begin
          rx_capture = 1'b1;
          rx_next    = RX_HOLD;
        end
      end
      RX_HOLD: begin
        rx_ack_toggle = 1'b1;
        rx_next       = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      net_in_ack  <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      rx_state <= rx_next;
      if (rx_ack_toggle) net_in_ack <= ~net_in_ack;
      if (rx_capture) begin
        fifo_mem[wr_ptr] <= net_in_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (rx_pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + 2'(rx_capture) - 2'(rx_pop);
    end
  end
`else
  // The ack is withheld until the processor takes the flit, which stalls
  // the router for as long as rx_ready stays low.
  assign rx_valid = (rx_state == RX_HOLD);

  always_comb begin
    rx_next       = rx_state;
    rx_capture    = 1'b0;
    rx_ack_toggle = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (req_sync != net_in_ack) begin
          rx_capture = 1'b1;
          rx_next    = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (rx_ready) begin
          rx_ack_toggle = 1'b1;
          rx_next       = RX_IDLE;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      net_in_ack <= 1'b0;
      rx_data    <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_capture)    rx_data    <= net_in_data;
      if (rx_ack_toggle) net_in_ack <= ~net_in_ack;
    end
  end
`endif

endmodule

// File: tb/tb_proc_net_interface.sv
// tb_proc_net_interface -- directed bench for proc_net_interface with the
// default configuration (N=32, XW=YW=1, SRCX=SRCY=0, SYNC_STAGES=2).
// The bench plays both the processor and the router. Expectations that
// differ with PNI_RX_BUF_EN are selected with the same macro.
module tb_proc_net_interface;

  localparam int N  = 32;
  localparam int XW = 1;
  localparam int YW = 1;
  localparam int PW = N - XW - YW - 2;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid;
  logic          tx_ready;
  logic [XW-1:0] tx_dst_x;
  logic [YW-1:0] tx_dst_y;
  logic [PW-1:0] tx_payload;
  logic          tx_err;
  logic          rx_valid;
  logic          rx_ready;
  logic [N-1:0]  rx_data;
  logic          net_out_req;
  logic [N-1:0]  net_out_data;
  logic          net_out_ack;
  logic          net_in_req;
  logic [N-1:0]  net_in_data;
  logic          net_in_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  proc_net_interface #(
    .N(N), .XW(XW), .YW(YW), .SRCX(0), .SRCY(0), .SYNC_STAGES(SS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_dst_x     (tx_dst_x),
    .tx_dst_y     (tx_dst_y),
    .tx_payload   (tx_payload),
    .tx_err       (tx_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .net_out_req  (net_out_req),
    .net_out_data (net_out_data),
    .net_out_ack  (net_out_ack),
    .net_in_req   (net_in_req),
    .net_in_data  (net_in_data),
    .net_in_ack   (net_in_ack)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [XW-1:0] dx, input logic [YW-1:0] dy,
                       input logic [PW-1:0] pl);
    tx_dst_x   = dx;
    tx_dst_y   = dy;
    tx_payload = pl;
    tx_valid   = 1'b1;
    step();
    tx_valid   = 1'b0;
  endtask

  task automatic wait_tx_ready(output int cycles);
    cycles = 0;
    while (!tx_ready && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic wait_rx_valid();
    for (int i = 0; i < 10 && !rx_valid; i++) step();
  endtask

  task automatic wait_in_acked();
    for (int i = 0; i < 10 && (net_in_ack !== net_in_req); i++) step();
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tx_valid = 1'b0; tx_dst_x = '0; tx_dst_y = '0; tx_payload = '0;
    rx_ready = 1'b0; net_out_ack = 1'b0; net_in_req = 1'b0; net_in_data = '0;
    repeat (3) step();
    n_cmp++;
    if ({net_out_req, net_in_ack, rx_valid, tx_err, tx_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req/ack/rxv/err/rdy=%b expected 00000",
               {net_out_req, net_in_ack, rx_valid, tx_err, tx_ready});
    end
    n_cmp++;
    if (net_out_data !== 32'h0 || rx_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got out=%h rx=%h expected 0/0", net_out_data, rx_data);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", tx_ready);
    end
  endtask

  task automatic test_send_and_hold();
    int cyc;
    offer(1'b1, 1'b1, 28'h0001234);
    n_cmp++;
    if (net_out_data !== 32'hF000_1234 || net_out_req !== 1'b0 || tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL send_accept: got data=%h req=%b rdy=%b expected F0001234/0/0",
               net_out_data, net_out_req, tx_ready);
    end
    step();
    n_cmp++;
    if (net_out_req !== 1'b1) begin
      n_fail++;
      $display("FAIL send_req_toggle: got %b expected 1", net_out_req);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (tx_ready !== 1'b0 || net_out_data !== 32'hF000_1234 || net_out_req !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_ack[%0d]: got rdy=%b data=%h req=%b expected 0/F0001234/1",
                 i, tx_ready, net_out_data, net_out_req);
      end
    end
    net_out_ack = 1'b1;
    wait_tx_ready(cyc);
    n_cmp++;
    if (tx_ready !== 1'b1 || cyc > SS + 1) begin
      n_fail++;
      $display("FAIL ack_release: got rdy=%b after %0d cycles expected 1 within %0d",
               tx_ready, cyc, SS + 1);
    end
  endtask

  task automatic test_self_drop();
    offer(1'b0, 1'b0, 28'h0000055);
    n_cmp++;
    if (tx_err !== 1'b1 || net_out_req !== 1'b1 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL self_drop: got err=%b req=%b rdy=%b expected 1/1/1",
               tx_err, net_out_req, tx_ready);
    end
    step();
    n_cmp++;
    if (tx_err !== 1'b0 || net_out_req !== 1'b1) begin
      n_fail++;
      $display("FAIL self_drop_pulse: got err=%b req=%b expected 0/1", tx_err, net_out_req);
    end
  endtask

  task automatic test_second_send();
    int cyc;
    offer(1'b1, 1'b0, 28'hABCDEF0);
    n_cmp++;
    if (net_out_data !== 32'hAABC_DEF0) begin
      n_fail++;
      $display("FAIL send2_data: got %h expected AABCDEF0", net_out_data);
    end
    step();
    n_cmp++;
    if (net_out_req !== 1'b0) begin
      n_fail++;
      $display("FAIL send2_req_toggle: got %b expected 0", net_out_req);
    end
    net_out_ack = 1'b0;
    wait_tx_ready(cyc);
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send2_ack_release: got rdy=%b after %0d cycles expected 1", tx_ready, cyc);
    end
  endtask

  task automatic test_rx_backpressure();
    logic exp_ack;
`ifdef PNI_RX_BUF_EN
    exp_ack = 1'b1;
`else
    exp_ack = 1'b0;
`endif
    rx_ready    = 1'b0;
    net_in_data = 32'hDEAD_BEEF;
    net_in_req  = 1'b1;
    wait_rx_valid();
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rx_capture: got v=%b data=%h expected 1/DEADBEEF", rx_valid, rx_data);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (rx_valid !== 1'b1 || rx_data !== 32'hDEAD_BEEF || net_in_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL rx_hold[%0d]: got v=%b data=%h ack=%b expected 1/DEADBEEF/%b",
                 i, rx_valid, rx_data, net_in_ack, exp_ack);
      end
    end
    pop_one();
    n_cmp++;
    if (net_in_ack !== 1'b1 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_consume: got ack=%b v=%b expected 1/0", net_in_ack, rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    // Starts with net_in_req = net_in_ack = 1.
    net_in_data = 32'h1111_1111;
    net_in_req  = 1'b0;
`ifdef PNI_RX_BUF_EN
    wait_in_acked();
    n_cmp++;
    if (net_in_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ack_a: got %b expected 0", net_in_ack);
    end
    net_in_data = 32'h2222_2222;
    net_in_req  = 1'b1;
    wait_in_acked();
    n_cmp++;
    if (net_in_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ack_b: got %b expected 1", net_in_ack);
    end
    net_in_data = 32'h3333_3333;
    net_in_req  = 1'b0;
    repeat (10) step();
    n_cmp++;
    if (net_in_ack !== 1'b1 || rx_data !== 32'h1111_1111 || rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_full: got ack=%b data=%h v=%b expected 1/11111111/1",
               net_in_ack, rx_data, rx_valid);
    end
    pop_one();
    n_cmp++;
    if (rx_data !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL b2b_pop_a: got %h expected 22222222", rx_data);
    end
    wait_in_acked();
    n_cmp++;
    if (net_in_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ack_c: got %b expected 0", net_in_ack);
    end
    pop_one();
    n_cmp++;
    if (rx_data !== 32'h3333_3333 || rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_pop_b: got data=%h v=%b expected 33333333/1", rx_data, rx_valid);
    end
    pop_one();
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_empty: got v=%b expected 0", rx_valid);
    end
`else
    wait_rx_valid();
    repeat (5) step();
    n_cmp++;
    if (rx_data !== 32'h1111_1111 || net_in_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_hold_a: got data=%h ack=%b expected 11111111/1", rx_data, net_in_ack);
    end
    pop_one();
    n_cmp++;
    if (net_in_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ack_a: got %b expected 0", net_in_ack);
    end
    net_in_data = 32'h2222_2222;
    net_in_req  = 1'b1;
    wait_rx_valid();
    n_cmp++;
    if (rx_data !== 32'h2222_2222 || net_in_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold_b: got data=%h ack=%b expected 22222222/0", rx_data, net_in_ack);
    end
    pop_one();
    n_cmp++;
    if (net_in_ack !== 1'b1 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ack_b: got ack=%b v=%b expected 1/0", net_in_ack, rx_valid);
    end
`endif
  endtask

  task automatic test_reset_mid();
    offer(1'b1, 1'b1, 28'h0000042);
    step();
    n_cmp++;
    if (net_out_req !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre_req: got %b expected 1", net_out_req);
    end
    rst = 1'b1;
    net_out_ack = 1'b0; net_in_req = 1'b0; net_in_data = '0;
    step();
    n_cmp++;
    if (net_out_req !== 1'b0 || tx_ready !== 1'b0 || net_in_ack !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_in_reset: got req=%b rdy=%b ack=%b v=%b expected 0/0/0/0",
               net_out_req, tx_ready, net_in_ack, rx_valid);
    end
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (tx_ready !== 1'b1 || net_out_req !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_release: got rdy=%b req=%b expected 1/0", tx_ready, net_out_req);
    end
  endtask

  task automatic test_concurrent();
    int cyc;
    rx_ready    = 1'b1;
    net_in_data = 32'hCAFE_F00D;
    net_in_req  = 1'b1;
    offer(1'b0, 1'b1, 28'h0000777);
    n_cmp++;
    if (net_out_data !== 32'h5000_0777) begin
      n_fail++;
      $display("FAIL conc_tx_data: got %h expected 50000777", net_out_data);
    end
    step();
    n_cmp++;
    if (net_out_req !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_tx_req: got %b expected 1", net_out_req);
    end
    wait_rx_valid();
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL conc_rx_data: got v=%b data=%h expected 1/CAFEF00D", rx_valid, rx_data);
    end
    step();
    n_cmp++;
    if (net_in_ack !== 1'b1 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL conc_rx_ack: got ack=%b v=%b expected 1/0", net_in_ack, rx_valid);
    end
    rx_ready    = 1'b0;
    net_out_ack = 1'b1;
    wait_tx_ready(cyc);
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_tx_done: got rdy=%b after %0d cycles expected 1", tx_ready, cyc);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_send_and_hold();
    test_self_drop();
    test_second_send();
    test_rx_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_concurrent();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
